blast_ctrl: RTL and testbench

Bomb-explosion controller on the maze RAM's controller port. It accepts one blast request at a time and paints flame tiles outward from the bomb cell along four directions. It holds the flames for a fixed number of frames, then erases them, breaking bricks on the way. Every RAM read and write happens only during video blanking (`active` low), because the maze RAM read address serves the display while `active` is high.

---
 rtl/blast_ctrl_if.sv | 26 ++
 rtl/blast_ctrl.sv | 163 ++++++++++++++++
 tb/tb_blast_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/blast_ctrl_if.sv
// blast_ctrl_if: request/ack, frame timing and maze RAM controller-port signals
interface blast_ctrl_if;
   logic       blast_req;
   logic [4:0] blast_x;
   logic [4:0] blast_y;
   logic [2:0] blast_radius;
   logic       blast_ack;
   logic       busy;
   logic       done;
   logic       brick_broken;
   logic       frame_tick;
   logic       active;
   logic [9:0] ram_raddr;
   logic [3:0] ram_rdata;
   logic [9:0] ram_waddr;
   logic [3:0] ram_wdata;
   logic       ram_we;
   modport slave (
      input  blast_req, blast_x, blast_y, blast_radius, frame_tick, active, ram_rdata,
      output blast_ack, busy, done, brick_broken, ram_raddr, ram_waddr, ram_wdata, ram_we
   );
   modport master (
      output blast_req, blast_x, blast_y, blast_radius, frame_tick, active, ram_rdata,
      input  blast_ack, busy, done, brick_broken, ram_raddr, ram_waddr, ram_wdata, ram_we
   );
endinterface

// File: rtl/blast_ctrl.sv
// blast_ctrl: paints flames from a bomb cell in four directions, holds them, then clears them,
// touching the maze RAM only while the display is blanked
module blast_ctrl #(
   parameter int FLAME_FRAMES = 30,
   parameter int MAZEX        = 25,
   parameter int MAZEY        = 17
) (
   input logic        clk,
   input logic        reset_n,
   blast_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CENTER, RD, CHK, WR, NEXT, HOLD, DONE} state_t;
   localparam int FW = $clog2(FLAME_FRAMES + 1);
   localparam logic signed [6:0] MX = 7'(MAZEX);
   localparam logic signed [6:0] MY = 7'(MAZEY);
   localparam logic [3:0] EMPTY = 4'd0, BRICK = 4'd2, FLAME = 4'd3;
   state_t          state_q, state_d;
   logic            phase_q, phase_d;
   logic [4:0]      x_q, x_d, y_q, y_d;
   logic [2:0]      r_q, r_d;
   logic [1:0]      dir_q, dir_d;
   logic [3:0]      k_q, k_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic            brick_q, brick_d, ack_q, ack_d, done_q, done_d;
   logic [9:0]      raddr_q, raddr_d, waddr_q, waddr_d;
   logic [3:0]      wdata_q, wdata_d;
   logic signed [6:0] sk, tx, ty;
   logic            end_dir, in_maze, writing, blast_hit, clear_hit;
   assign sk = $signed({3'b0, k_q});
   assign tx = $signed({2'b0, x_q}) + (dir_q == 2'd0 ? sk : dir_q == 2'd1 ? -sk : 7'sd0);
   assign ty = $signed({2'b0, y_q}) + (dir_q == 2'd2 ? sk : dir_q == 2'd3 ? -sk : 7'sd0);
   assign end_dir = k_q > {1'b0, r_q} || tx[6] || ty[6] || tx >= MX || ty >= MY;
   assign in_maze = $signed({2'b0, bus.blast_x}) < MX && $signed({2'b0, bus.blast_y}) < MY;
   assign blast_hit = bus.ram_rdata == EMPTY || bus.ram_rdata == BRICK || bus.ram_rdata == FLAME;
   assign clear_hit = bus.ram_rdata == FLAME;
   // writes fire only in a blanked cycle, so the strobe qualifies the held address/data with active
   assign writing = (state_q == CENTER || state_q == WR) && !bus.active;
   assign bus.ram_we       = writing;
   assign bus.brick_broken = writing && brick_q;
   assign bus.blast_ack    = ack_q;
   assign bus.done         = done_q;
   assign bus.busy         = state_q != IDLE || done_q;
   assign bus.ram_raddr    = raddr_q;
   assign bus.ram_waddr    = waddr_q;
   assign bus.ram_wdata    = wdata_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         phase_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         r_q     <= '0;
         dir_q   <= '0;
         k_q     <= '0;
         fcnt_q  <= '0;
         brick_q <= 1'b0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         raddr_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         x_q     <= x_d;
         y_q     <= y_d;
         r_q     <= r_d;
         dir_q   <= dir_d;
         k_q     <= k_d;
         fcnt_q  <= fcnt_d;
         brick_q <= brick_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         raddr_q <= raddr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      x_d     = x_q;
      y_d     = y_q;
      r_d     = r_q;
      dir_d   = dir_q;
      k_d     = k_q;
      fcnt_d  = fcnt_q;
      brick_d = brick_q;
      ack_d   = 1'b0;
      done_d  = 1'b0;
      raddr_d = '0;
      waddr_d = '0;
      wdata_d = '0;
      case (state_q)
         IDLE: if (bus.blast_req && !done_q) begin
            x_d     = bus.blast_x;
            y_d     = bus.blast_y;
            r_d     = bus.blast_radius;
            ack_d   = 1'b1;
            phase_d = 1'b0;
            fcnt_d  = '0;
            brick_d = 1'b0;
            state_d = in_maze ? CENTER : DONE;
            waddr_d = in_maze ? {bus.blast_y, bus.blast_x} : 10'd0;
            wdata_d = in_maze ? FLAME : EMPTY;
         end
         CENTER: begin
            waddr_d = bus.active ? waddr_q : 10'd0;
            wdata_d = bus.active ? wdata_q : 4'd0;
            if (!bus.active) begin
               state_d = NEXT;
               dir_d   = 2'd0;
               k_d     = 4'd1;
            end
         end
         NEXT: if (end_dir) begin
            state_d = dir_q == 2'd3 ? (phase_q ? DONE : HOLD) : NEXT;
            dir_d   = dir_q + 2'd1;
            k_d     = 4'd1;
         end else begin
            state_d = RD;
            raddr_d = {ty[4:0], tx[4:0]};
         end
         RD: begin
            raddr_d = raddr_q;
            if (!bus.active) state_d = CHK;
         end
         CHK: begin
            // k = 15 exceeds any radius, so the next NEXT closes this direction
            state_d = NEXT;
            k_d     = 4'hF;
            if (phase_q ? clear_hit : blast_hit) begin
               state_d = WR;
               waddr_d = raddr_q;
               wdata_d = phase_q ? EMPTY : FLAME;
               brick_d = !phase_q && bus.ram_rdata == BRICK;
               k_d     = (!phase_q && bus.ram_rdata == BRICK) ? 4'hF : k_q + 4'd1;
            end
         end
         WR: begin
            waddr_d = bus.active ? waddr_q : 10'd0;
            wdata_d = bus.active ? wdata_q : 4'd0;
            if (!bus.active) begin
               state_d = NEXT;
               brick_d = 1'b0;
            end
         end
         HOLD: if (bus.frame_tick) begin
            fcnt_d = fcnt_q + FW'(1);
            if (fcnt_q == FW'(FLAME_FRAMES - 1)) begin
               fcnt_d  = '0;
               phase_d = 1'b1;
               state_d = CENTER;
               waddr_d = {y_q, x_q};
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_blast_ctrl.sv
// tb_blast_ctrl: directed scenarios against a behavioural maze RAM with a blanking-aware read port
module tb_blast_ctrl;
   logic clk = 0;
   logic reset_n;
   always #5 clk = ~clk;
   blast_ctrl_if bus();
   blast_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   logic [3:0]  mem [1024];
   logic        clr = 0, poke = 0, tog = 0;
   logic [9:0]  poke_a = 0;
   logic [3:0]  poke_d = 0;
   logic [14:0] wlog [$];
   int          checks = 0, errors = 0, rdcnt = 0, acnt = 0;
   logic [9:0]  e1 [$], e2 [$], e3 [$];
   // while the display is active the RAM serves address 0x3FF, which holds a wall
   always @(posedge clk) begin
      if (clr) for (int i = 0; i < 1024; i++) mem[i] <= 4'd0;
      else if (poke) mem[poke_a] <= poke_d;
      else if (bus.ram_we === 1'b1) mem[bus.ram_waddr] <= bus.ram_wdata;
      bus.ram_rdata <= bus.active ? mem[10'h3FF] : mem[bus.ram_raddr];
   end
   initial begin
      bus.active = 0;
      forever begin
         @(posedge clk);
         #2;
         if (tog) begin
            acnt++;
            if (acnt == 2) begin
               bus.active = ~bus.active;
               acnt = 0;
            end
         end else bus.active = 0;
      end
   end
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.ram_we === 1'b1) begin
         wlog.push_back({bus.brick_broken, bus.ram_wdata, bus.ram_waddr});
         chk("we_in_blank", 32'(bus.active), 0);
         chk("waddr_range", 32'(bus.ram_waddr[4:0] < 5'd25 && bus.ram_waddr[9:5] < 5'd17), 1);
      end
      if (bus.ram_raddr !== 10'd0) begin
         rdcnt++;
         chk("raddr_range", 32'(bus.ram_raddr[4:0] < 5'd25 && bus.ram_raddr[9:5] < 5'd17), 1);
      end
   end
   function automatic logic [9:0] a(int x, int y);
      return 10'(y * 32 + x);
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr_mem(logic [9:0] ad, logic [3:0] d);
      poke_a = ad;
      poke_d = d;
      poke = 1;
      tick();
      poke = 0;
   endtask
   task automatic start(int x, int y, int r);
      bus.blast_x = 5'(x);
      bus.blast_y = 5'(y);
      bus.blast_radius = 3'(r);
      bus.blast_req = 1;
      tick();
      bus.blast_req = 0;
   endtask
   task automatic frames(int n);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1;
         tick();
         bus.frame_tick = 0;
         tick();
      end
   endtask
   task automatic wait_done(string tag, int budget);
      int n = 0;
      while (bus.done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.done), 1);
   endtask
   task automatic check_idle(string tag);
      chk({tag, " ack"}, 32'(bus.blast_ack), 0);
      chk({tag, " busy"}, 32'(bus.busy), 0);
      chk({tag, " done"}, 32'(bus.done), 0);
      chk({tag, " brick"}, 32'(bus.brick_broken), 0);
      chk({tag, " we"}, 32'(bus.ram_we), 0);
      chk({tag, " raddr"}, 32'(bus.ram_raddr), 0);
      chk({tag, " waddr"}, 32'(bus.ram_waddr), 0);
      chk({tag, " wdata"}, 32'(bus.ram_wdata), 0);
   endtask
   task automatic chk_log(string tag, int base, input logic [9:0] ea[$], input logic [3:0] d, input int bi);
      for (int i = 0; i < ea.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), base + i < wlog.size() ? 32'(wlog[base + i]) : 32'hDEAD,
             32'({(i == bi), d, ea[i]}));
   endtask
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      e1 = '{a(5,5), a(6,5), a(7,5), a(4,5), a(3,5), a(5,6), a(5,7), a(5,4), a(5,3)};
      e2 = '{a(5,5), a(6,5), a(5,6), a(5,7), a(5,8), a(5,4), a(5,3), a(5,2)};
      e3 = '{a(0,0), a(1,0), a(2,0), a(3,0), a(0,1), a(0,2), a(0,3)};
      reset_n = 0;
      bus.blast_req = 0;
      bus.blast_x = 0;
      bus.blast_y = 0;
      bus.blast_radius = 0;
      bus.frame_tick = 0;
      repeat (3) tick();
      check_idle("reset");
      reset_n = 1;
      clr = 1;
      tick();
      clr = 0;
      wr_mem(10'h3FF, 4'd1);
      // empty region, radius 2
      start(5, 5, 2);
      chk("s1 ack", 32'(bus.blast_ack), 1);
      chk("s1 busy", 32'(bus.busy), 1);
      bus.blast_req = 1;
      tick();
      bus.blast_req = 0;
      chk("busy req no ack", 32'(bus.blast_ack), 0);
      repeat (80) tick();
      chk("s1 blast count", wlog.size(), 9);
      chk_log("s1 blast", 0, e1, 4'd3, -1);
      chk("s1 hold busy", 32'(bus.busy), 1);
      frames(29);
      chk("s1 no early clear", wlog.size(), 9);
      frames(1);
      wait_done("s1 done", 200);
      chk("s1 busy at done", 32'(bus.busy), 1);
      chk("s1 clear count", wlog.size(), 18);
      chk_log("s1 clear", 9, e1, 4'd0, -1);
      tick();
      chk("s1 idle busy", 32'(bus.busy), 0);
      chk("s1 done pulse", 32'(bus.done), 0);
      // brick east, wall west, radius 3
      wlog.delete();
      wr_mem(a(6,5), 4'd2);
      wr_mem(a(4,5), 4'd1);
      start(5, 5, 3);
      repeat (80) tick();
      chk("s2 blast count", wlog.size(), 8);
      chk_log("s2 blast", 0, e2, 4'd3, 1);
      chk("s2 brick flamed", 32'(mem[a(6,5)]), 3);
      frames(30);
      wait_done("s2 done", 200);
      chk("s2 clear count", wlog.size(), 16);
      chk_log("s2 clear", 8, e2, 4'd0, -1);
      chk("s2 brick gone", 32'(mem[a(6,5)]), 0);
      chk("s2 wall kept", 32'(mem[a(4,5)]), 1);
      tick();
      wr_mem(a(4,5), 4'd0);
      // corner, radius 3
      wlog.delete();
      start(0, 0, 3);
      repeat (80) tick();
      chk("s3 blast count", wlog.size(), 7);
      chk_log("s3 blast", 0, e3, 4'd3, -1);
      frames(30);
      wait_done("s3 done", 200);
      chk("s3 clear count", wlog.size(), 14);
      chk_log("s3 clear", 7, e3, 4'd0, -1);
      tick();
      // blanking toggles every 2 cycles
      wlog.delete();
      tog = 1;
      start(5, 5, 2);
      repeat (200) tick();
      chk("s4 blast count", wlog.size(), 9);
      chk_log("s4 blast", 0, e1, 4'd3, -1);
      for (int i = 0; i < 9; i++) chk($sformatf("s4 mem[%0d]", i), 32'(mem[e1[i]]), 3);
      frames(30);
      wait_done("s4 done", 400);
      chk("s4 clear count", wlog.size(), 18);
      for (int i = 0; i < 9; i++) chk($sformatf("s4 cleared[%0d]", i), 32'(mem[e1[i]]), 0);
      tick();
      tog = 0;
      repeat (3) tick();
      // out-of-range request
      begin
         int nw, nr;
         nw = wlog.size();
         nr = rdcnt;
         start(25, 3, 1);
         chk("s5 ack", 32'(bus.blast_ack), 1);
         chk("s5 not yet done", 32'(bus.done), 0);
         tick();
         chk("s5 done", 32'(bus.done), 1);
         chk("s5 busy at done", 32'(bus.busy), 1);
         tick();
         chk("s5 idle", 32'(bus.busy), 0);
         chk("s5 no writes", wlog.size(), nw);
         chk("s5 no reads", rdcnt, nr);
      end
      // reset mid-blast
      start(5, 5, 2);
      repeat (10) tick();
      #2 reset_n = 0;
      #1 check_idle("async rst");
      tick();
      reset_n = 1;
      tick();
      start(5, 5, 2);
      chk("s6 ack", 32'(bus.blast_ack), 1);
      repeat (80) tick();
      frames(30);
      wait_done("s6 done", 200);
      for (int i = 0; i < 9; i++) chk($sformatf("s6 cleared[%0d]", i), 32'(mem[e1[i]]), 0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
